// File: rtl/jtcps1_vram_arb.sv
// Round-robin arbiter for the single VRAM read port (scroll, object DMA, palette DMA).
// Routes vram_ok back to the granted requester only and caps bursts when others wait.

module jtcps1_vram_arb_okreg (
  input  logic clk,
  input  logic rst_n,
  input  logic fwd,
  output logic ok
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ok <= 1'b0;
    else        ok <= fwd;
endmodule

module jtcps1_vram_arb #(
  parameter int MAXBURST = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scr_cs,
  input  logic [17:1] scr_addr,
  output logic        scr_ok,
  input  logic        obj_cs,
  input  logic [17:1] obj_addr,
  output logic        obj_ok,
  input  logic        pal_cs,
  input  logic [17:1] pal_addr,
  output logic        pal_ok,
  output logic [17:1] vram_addr,
  output logic        vram_cs,
  input  logic        vram_ok,
  output logic [2:0]  gnt
);
  localparam int         NREQ = 3;
  localparam logic [1:0] PAL  = 2'd2;

  typedef enum logic [1:0] {IDLE, GRANT, SWITCH} st_t;

  st_t                   st, st_nx;
  logic [NREQ-1:0]       cs_v, gnt_nx, ok_nx, ok_v;
  logic [NREQ-1:0][16:0] addr_v;
  logic [16:0]           addr_nx, cur_addr;
  logic [1:0]            last, last_nx, cand1, cand2, pick;
  logic [3:0]            bcnt, bcnt_nx, bcnt_inc;
  logic                  ok_mask, mask_nx, cs_nx, take, others, limit;

  assign cs_v   = {pal_cs, obj_cs, scr_cs};
  assign addr_v = {pal_addr, obj_addr, scr_addr};

  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i == PAL) ? 2'd0 : i + 2'd1;
  endfunction

  // search order starts after the last granted requester and wraps back to it
  assign cand1 = rr_next(last);
  assign cand2 = rr_next(cand1);
  assign pick  = cs_v[cand1] ? cand1 : (cs_v[cand2] ? cand2 : last);

  assign cur_addr = addr_v[last];
  assign take     = vram_ok & ~ok_mask;
  assign bcnt_inc = (bcnt == 4'hf) ? bcnt : bcnt + 4'd1;
  assign others   = |(cs_v & ~gnt);
  assign limit    = (MAXBURST != 0) && take && (int'(bcnt_inc) >= MAXBURST) && others;

  always_comb begin
    st_nx   = st;
    gnt_nx  = gnt;
    last_nx = last;
    cs_nx   = vram_cs;
    addr_nx = vram_addr;
    mask_nx = ok_mask;
    bcnt_nx = bcnt;
    ok_nx   = '0;
    case (st)
      IDLE: if (|cs_v) begin
        st_nx   = GRANT;
        gnt_nx  = 3'b001 << pick;
        last_nx = pick;
        cs_nx   = 1'b1;
        addr_nx = addr_v[pick];
        mask_nx = 1'b1;
        bcnt_nx = '0;
      end
      GRANT: begin
        // data arriving right after an address change belongs to the old address
        addr_nx = cur_addr;
        mask_nx = (cur_addr != vram_addr);
        ok_nx   = take ? gnt : '0;
        if (take) bcnt_nx = bcnt_inc;
        if (!cs_v[last] || limit) st_nx = SWITCH;
      end
      SWITCH: begin
        st_nx  = IDLE;
        gnt_nx = '0;
        cs_nx  = 1'b0;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      gnt       <= '0;
      last      <= PAL;
      vram_cs   <= 1'b0;
      vram_addr <= '0;
      ok_mask   <= 1'b0;
      bcnt      <= '0;
    end else begin
      st        <= st_nx;
      gnt       <= gnt_nx;
      last      <= last_nx;
      vram_cs   <= cs_nx;
      vram_addr <= addr_nx;
      ok_mask   <= mask_nx;
      bcnt      <= bcnt_nx;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_ok
    jtcps1_vram_arb_okreg u_ok (
      .clk   (clk),
      .rst_n (rst_n),
      .fwd   (ok_nx[i]),
      .ok    (ok_v[i])
    );
  end

  assign scr_ok = ok_v[0];
  assign obj_ok = ok_v[1];
  assign pal_ok = ok_v[2];
endmodule
